// File: rtl/v2p_req_scheduler_if.sv
// ---------------------------------------------------------------------------
// v2p_req_scheduler_if
//  Bundles the signals between the V2P request scheduler and its
//  neighbours (the per-channel req_fifos and selected_channel_ctl).
//
//  Signals
//   i_req_empty           per-channel req_fifo empty flag, bit n = channel n
//   i_chan_en             per-channel enable mask (0 = never grant)
//   old_selected_channel  from selected_channel_ctl: [MSB] Ready, [NCH-1:0] last grant
//   new_selected_channel  to selected_channel_ctl: {1'b1, one-hot} during ISSUE, else 0
//   o_grant_vld           one-cycle pulse in the ISSUE cycle
//   o_grant_idx           index of the current/last grant
//   o_busy                scheduler is not idle
//   o_timeout_err         sticky latch-acknowledge timeout flag
//
//  Modports
//   master  the scheduler itself
//   slave   the environment (fifos + selected_channel_ctl)
// ---------------------------------------------------------------------------
interface v2p_req_scheduler_if #(
    parameter int CHANNEL_WIDTH = 9
);
    localparam int NCH   = CHANNEL_WIDTH - 1;
    localparam int IDX_W = $clog2(NCH);

    logic [NCH-1:0]           i_req_empty;
    logic [NCH-1:0]           i_chan_en;
    logic [CHANNEL_WIDTH-1:0] old_selected_channel;
    logic [CHANNEL_WIDTH-1:0] new_selected_channel;
    logic                     o_grant_vld;
    logic [IDX_W-1:0]         o_grant_idx;
    logic                     o_busy;
    logic                     o_timeout_err;

    modport master (
        input  i_req_empty,
        input  i_chan_en,
        input  old_selected_channel,
        output new_selected_channel,
        output o_grant_vld,
        output o_grant_idx,
        output o_busy,
        output o_timeout_err
    );

    modport slave (
        output i_req_empty,
        output i_chan_en,
        output old_selected_channel,
        input  new_selected_channel,
        input  o_grant_vld,
        input  o_grant_idx,
        input  o_busy,
        input  o_timeout_err
    );
endinterface

// File: rtl/v2p_req_scheduler.sv
// ---------------------------------------------------------------------------
// v2p_req_scheduler
//  Arbitrates the eight V2P request channels (CEU, DB WQE, WP WQE, WP DATA,
//  RTC CQ, RRC DATA, EE RQ WQE, EE DATA) onto the shared MPT/MTT lookup path.
//  One pending channel is chosen, presented to selected_channel_ctl for a
//  single ISSUE cycle, and the Ready bit coming back is followed through
//  latch (Ready rises) and MPT consumption (Ready falls) before the next
//  arbitration. Channel 0 (CEU) can be given strict priority; the remaining
//  channels share a round-robin pointer.
//
//  Parameters
//   CHANNEL_WIDTH  channel bits + Ready bit (MSB)
//   CEU_PRIORITY   1: ch0 strict priority, RR over ch1..N-1; 0: RR over all
//   ACK_TIMEOUT    WAIT_LATCH cycles allowed before the grant is abandoned
//
//  Ports
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    v2p_req_scheduler_if.master (fifo flags, enables, ctl handshake,
//          grant/status outputs)
// ---------------------------------------------------------------------------
module v2p_req_scheduler #(
    parameter int CHANNEL_WIDTH = 9,
    parameter bit CEU_PRIORITY  = 1'b1,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    v2p_req_scheduler_if.master     bus
);
    localparam int NCH   = CHANNEL_WIDTH - 1;
    localparam int IDX_W = $clog2(NCH);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    // Lowest member of the round-robin set: reset value of the pointer and
    // the wrap target after the highest channel.
    localparam logic [IDX_W-1:0] PTR_BASE = CEU_PRIORITY ? IDX_W'(1) : IDX_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LATCH,
        ST_WAIT_DONE,
        ST_SETTLE
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t                   r_state;
    logic [IDX_W-1:0]         r_ptr;
    logic [CNT_W-1:0]         r_cnt;
    logic [CHANNEL_WIDTH-1:0] r_new_sel;
    logic                     r_grant_vld;
    logic [IDX_W-1:0]         r_grant_idx;
    logic                     r_timeout_err;

    // -----------------------------------------------------------------------
    // Next-state / combinational signals
    // -----------------------------------------------------------------------
    state_t                   w_state_next;
    logic [IDX_W-1:0]         w_ptr_next;
    logic [CNT_W-1:0]         w_cnt_next;
    logic [CHANNEL_WIDTH-1:0] w_new_sel_next;
    logic                     w_grant_vld_next;
    logic [IDX_W-1:0]         w_grant_idx_next;
    logic                     w_timeout_err_next;

    logic                     w_ready;
    logic [NCH-1:0]           w_pending;
    logic [NCH-1:0]           w_rr_pending;
    logic [IDX_W-1:0]         w_cand_idx [NCH];
    logic [NCH-1:0]           w_rr_hit;
    logic [IDX_W-1:0]         w_rr_idx;
    logic                     w_ceu_win;
    logic [IDX_W-1:0]         w_grant_idx;
    logic [NCH-1:0]           w_grant_onehot;
    logic [IDX_W-1:0]         w_ptr_adv;
    logic [CNT_W-1:0]         w_cnt_inc;

    assign w_ready   = bus.old_selected_channel[CHANNEL_WIDTH-1];
    assign w_pending = ~bus.i_req_empty & bus.i_chan_en;

    // With CEU priority, ch0 is outside the RR set so the search can walk
    // through index 0 on wrap without ever landing on it.
    assign w_rr_pending = CEU_PRIORITY ? (w_pending & ~NCH'(1)) : w_pending;

    // Candidate gi is the channel gi steps above the pointer. The 3-bit add
    // wraps naturally because the channel count is a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rr_cand
            assign w_cand_idx[gi] = r_ptr + IDX_W'(gi);
            assign w_rr_hit[gi]   = w_rr_pending[w_cand_idx[gi]];
        end
    endgenerate

    // Smallest offset from the pointer wins: scan from the far end so the
    // nearest hit overwrites the others.
    always_comb begin
        w_rr_idx = r_ptr;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_rr_hit[i]) begin
                w_rr_idx = w_cand_idx[i];
            end
        end
    end

    assign w_ceu_win   = CEU_PRIORITY && w_pending[0];
    assign w_grant_idx = w_ceu_win ? '0 : w_rr_idx;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_onehot
            assign w_grant_onehot[gi] = (w_grant_idx == IDX_W'(gi));
        end
    endgenerate

    assign w_ptr_adv = (r_grant_idx == IDX_W'(NCH - 1)) ? PTR_BASE
                                                        : r_grant_idx + IDX_W'(1);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // -----------------------------------------------------------------------
    // FSM: next state and registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_ptr_next         = r_ptr;
        w_cnt_next         = r_cnt;
        w_new_sel_next     = '0;
        w_grant_vld_next   = 1'b0;
        w_grant_idx_next   = r_grant_idx;
        w_timeout_err_next = r_timeout_err;

        case (r_state)
            ST_IDLE: begin
                // A Ready already high here belongs to someone else (or is
                // stale); hold off until it clears.
                if (!w_ready && (|w_pending)) begin
                    w_state_next     = ST_ISSUE;
                    w_new_sel_next   = {1'b1, w_grant_onehot};
                    w_grant_vld_next = 1'b1;
                    w_grant_idx_next = w_grant_idx;
                end
            end

            ST_ISSUE: begin
                // A CEU grant comes from the priority path and must not
                // disturb the round-robin order of the other channels.
                if (!(CEU_PRIORITY && (r_grant_idx == '0))) begin
                    w_ptr_next = w_ptr_adv;
                end
                w_cnt_next   = '0;
                w_state_next = ST_WAIT_LATCH;
            end

            ST_WAIT_LATCH: begin
                if (w_ready) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_WAIT_DONE;
                end else if (w_cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                    w_cnt_next         = '0;
                    w_timeout_err_next = 1'b1;
                    w_state_next       = ST_IDLE;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end

            ST_WAIT_DONE: begin
                // Ready drops once the MPT side has read the request.
                if (!w_ready) begin
                    w_state_next = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                // One dead cycle so the fifo pop shows up in i_req_empty
                // before the next arbitration.
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= PTR_BASE;
            r_cnt         <= '0;
            r_new_sel     <= '0;
            r_grant_vld   <= 1'b0;
            r_grant_idx   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ptr         <= w_ptr_next;
            r_cnt         <= w_cnt_next;
            r_new_sel     <= w_new_sel_next;
            r_grant_vld   <= w_grant_vld_next;
            r_grant_idx   <= w_grant_idx_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    assign bus.new_selected_channel = r_new_sel;
    assign bus.o_grant_vld          = r_grant_vld;
    assign bus.o_grant_idx          = r_grant_idx;
    assign bus.o_busy               = (r_state != ST_IDLE);
    assign bus.o_timeout_err        = r_timeout_err;

endmodule

// File: tb/tb_v2p_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_v2p_req_scheduler
//  Directed bench for v2p_req_scheduler (CEU_PRIORITY=1, ACK_TIMEOUT=15).
//  A small selected_channel_ctl model latches new_selected_channel into
//  old_selected_channel with Ready set, then drops Ready the following
//  cycle (MPT consumed), unless told to hold it or not to latch at all.
// ---------------------------------------------------------------------------
module tb_v2p_req_scheduler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    v2p_req_scheduler_if #(.CHANNEL_WIDTH(9)) bus ();

    v2p_req_scheduler #(
        .CHANNEL_WIDTH (9),
        .CEU_PRIORITY  (1'b1),
        .ACK_TIMEOUT   (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // selected_channel_ctl model
    logic [8:0] ctl_old;
    logic [8:0] ctl_force_val = 9'h000;
    bit         ctl_latch_en  = 1'b1;
    bit         ctl_hold      = 1'b0;
    bit         ctl_override  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_old <= 9'h000;
        end else if (ctl_latch_en && bus.new_selected_channel[8]) begin
            ctl_old <= bus.new_selected_channel;
        end else if (ctl_old[8] && !ctl_hold) begin
            ctl_old <= {1'b0, ctl_old[7:0]};
        end
    end

    assign bus.old_selected_channel = ctl_override ? ctl_force_val : ctl_old;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for the next grant pulse, sampled on negedges.
    task automatic wait_grant(output logic [2:0] idx, output logic [8:0] sel,
                              output int cycles, output bit ok);
        ok = 1'b0; cycles = 0; idx = '0; sel = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            cycles++;
            if (bus.o_grant_vld) begin
                ok  = 1'b1;
                idx = bus.o_grant_idx;
                sel = bus.new_selected_channel;
                $display("t=%0t grant idx=%0d sel=%h after %0d cycles", $time, idx, sel, cycles);
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!bus.o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_req_empty = 8'hFF;
        bus.i_chan_en   = 8'hFF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.new_selected_channel !== 9'h000 || bus.o_grant_vld !== 1'b0 ||
            bus.o_grant_idx !== 3'd0 || bus.o_busy !== 1'b0 || bus.o_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: sel=%h vld=%b idx=%0d busy=%b err=%b, all zero required",
                     bus.new_selected_channel, bus.o_grant_vld, bus.o_grant_idx,
                     bus.o_busy, bus.o_timeout_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_grant_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b vld=%b required 0 0", bus.o_busy, bus.o_grant_vld);
        end
        $display("t=%0t reset released, idle with no requests", $time);
    endtask

    task automatic test_single_req();
        logic [2:0] idx; logic [8:0] sel; int cyc; bit ok; int seen;
        bus.i_req_empty = 8'hFB;
        wait_grant(idx, sel, cyc, ok);
        bus.i_req_empty = 8'hFF;
        checks++;
        if (!ok || sel !== 9'h104 || idx !== 3'd2) begin
            errors++;
            $display("FAIL single_issue: ok=%b sel=%h idx=%0d required sel=104 idx=2", ok, sel, idx);
        end
        @(negedge clk);
        checks++;
        if (bus.new_selected_channel !== 9'h000 || bus.o_grant_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_clear: sel=%h vld=%b required 000 0",
                     bus.new_selected_channel, bus.o_grant_vld);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_settle: busy=%b required 1", bus.o_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_back_idle: busy=%b required 0", bus.o_busy);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_grant_vld || bus.o_busy) seen++;
        end
        checks++;
        if (seen != 0 || bus.o_grant_idx !== 3'd2) begin
            errors++;
            $display("FAIL single_no_regrant: activity=%0d idx=%0d required 0 and idx 2", seen, bus.o_grant_idx);
        end
    endtask

    task automatic test_rr_fairness();
        int exp_idx [6] = '{1, 3, 7, 1, 3, 7};
        logic [2:0] idx; logic [8:0] sel; int cyc; bit ok;
        bus.i_req_empty = 8'h75;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            wait_grant(idx, sel, cyc, ok);
            if (k == 5) bus.i_req_empty = 8'hFF;
            checks++;
            if (!ok || idx !== 3'(exp_idx[k]) || (k > 0 && cyc != 5)) begin
                errors++;
                $display("FAIL rr_order[%0d]: ok=%b idx=%0d spacing=%0d required idx=%0d spacing=5",
                         k, ok, idx, cyc, exp_idx[k]);
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_ceu_preempt();
        int exp_idx [4] = '{4, 0, 5, 2};
        logic [2:0] idx; logic [8:0] sel; int cyc; bit ok;
        bus.i_req_empty = 8'hFF;
        apply_reset();
        bus.i_req_empty = 8'hEF;
        for (int k = 0; k < 4; k++) begin
            wait_grant(idx, sel, cyc, ok);
            // ch4 moves the pointer to 5; then ch0 plus ch2/ch5 contend.
            if (k == 0) bus.i_req_empty = 8'hDA;
            if (k == 1) bus.i_req_empty = 8'hDB;
            if (k == 3) bus.i_req_empty = 8'hFF;
            checks++;
            if (!ok || idx !== 3'(exp_idx[k])) begin
                errors++;
                $display("FAIL ceu_order[%0d]: ok=%b idx=%0d required %0d", k, ok, idx, exp_idx[k]);
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_timeout();
        logic [2:0] idx; logic [8:0] sel; int cyc; bit ok; int bad;
        ctl_latch_en = 1'b0;
        bus.i_req_empty = 8'hFB;
        wait_grant(idx, sel, cyc, ok);
        bus.i_req_empty = 8'hFF;
        checks++;
        if (!ok || idx !== 3'd2) begin
            errors++;
            $display("FAIL timeout_issue: ok=%b idx=%0d required 2", ok, idx);
        end
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.o_busy !== 1'b1 || bus.o_timeout_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early: %0d of 15 wait cycles not busy or flagged early, required 0", bad);
        end
        @(negedge clk);
        checks++;
        if (bus.o_timeout_err !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: err=%b busy=%b required 1 0", bus.o_timeout_err, bus.o_busy);
        end
        $display("t=%0t timeout abort observed err=%b", $time, bus.o_timeout_err);
        ctl_latch_en = 1'b1;
    endtask

    task automatic test_mask();
        int exp_idx [4] = '{4, 5, 4, 5};
        logic [2:0] idx; logic [8:0] sel; int cyc; bit ok; int seen;
        bus.i_req_empty = 8'h00;
        bus.i_chan_en   = 8'h30;
        for (int k = 0; k < 4; k++) begin
            wait_grant(idx, sel, cyc, ok);
            if (k == 3) bus.i_chan_en = 8'h00;
            checks++;
            if (!ok || idx !== 3'(exp_idx[k]) || sel[7:0] !== (8'h01 << exp_idx[k])) begin
                errors++;
                $display("FAIL mask_order[%0d]: ok=%b idx=%0d sel=%h required idx=%0d",
                         k, ok, idx, sel, exp_idx[k]);
            end
        end
        wait_idle(ok);
        ctl_force_val = 9'h100;
        ctl_override  = 1'b1;
        bus.i_chan_en = 8'h30;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_grant_vld || bus.o_busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL stale_ready_block: %0d active cycles with Ready stuck, required 0", seen);
        end
        checks++;
        if (bus.o_timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b required 1", bus.o_timeout_err);
        end
        ctl_override = 1'b0;
        wait_grant(idx, sel, cyc, ok);
        bus.i_req_empty = 8'hFF;
        bus.i_chan_en   = 8'hFF;
        checks++;
        if (!ok || idx !== 3'd4) begin
            errors++;
            $display("FAIL stale_ready_release: ok=%b idx=%0d required 4", ok, idx);
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        logic [2:0] idx; logic [8:0] sel; int cyc; bit ok;
        ctl_hold = 1'b1;
        bus.i_req_empty = 8'hFB;
        wait_grant(idx, sel, cyc, ok);
        bus.i_req_empty = 8'hFF;
        repeat (6) @(negedge clk);
        checks++;
        if (!ok || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_stuck: ok=%b busy=%b required busy 1 in WAIT_DONE", ok, bus.o_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.new_selected_channel !== 9'h000 || bus.o_grant_vld !== 1'b0 ||
            bus.o_grant_idx !== 3'd0 || bus.o_busy !== 1'b0 || bus.o_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: sel=%h vld=%b idx=%0d busy=%b err=%b, all zero required",
                     bus.new_selected_channel, bus.o_grant_vld, bus.o_grant_idx,
                     bus.o_busy, bus.o_timeout_err);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ctl_hold = 1'b0;
        bus.i_req_empty = 8'hF5;
        wait_grant(idx, sel, cyc, ok);
        bus.i_req_empty = 8'hFF;
        checks++;
        if (!ok || idx !== 3'd1) begin
            errors++;
            $display("FAIL midreset_pointer: ok=%b idx=%0d required 1", ok, idx);
        end
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_rr_fairness();
        test_ceu_preempt();
        test_timeout();
        test_mask();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
